// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the 10-bit symbol type, the four control-period
// codes, the running-disparity counter width and a byte popcount helper.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam int CNT_W = 6;

  localparam tmds_sym_t CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 transition-minimises the byte (registered
// together with de and the control pair), stage 2 applies DC balance using a
// private running disparity and registers the final 10-bit symbol.
//
// Ports:
//   clk   pixel clock
//   rst   asynchronous active-low reset
//   de    data enable, 1 = active video
//   d     8-bit pixel component
//   ctrl  {c1,c0} sent during blanking
//   sym   10-bit symbol, bit 0 transmitted first (2-cycle latency)
module tmds_channel_enc
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] d,
  input  logic [1:0] ctrl,
  output logic [9:0] sym
);

  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;

  // Stage 1
  logic [3:0] n1_d;
  logic       xnor_mode;
  logic       acc;
  logic [8:0] q_m_d;

  logic [8:0] q_m_q;
  logic       de_q;
  logic [1:0] ctrl_q;

  always_comb begin
    n1_d      = popcount8(d);
    xnor_mode = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
    q_m_d     = '0;
    acc       = d[0];
    q_m_d[0]  = acc;
    for (int i = 1; i < 8; i++) begin
      acc      = xnor_mode ? ~(acc ^ d[i]) : (acc ^ d[i]);
      q_m_d[i] = acc;
    end
    q_m_d[8] = ~xnor_mode;
  end

  // Stage 2
  logic [3:0]              n1q;
  logic [3:0]              n0q;
  logic signed [CNT_W-1:0] diff;     // N1q - N0q
  logic signed [CNT_W-1:0] q8_x2;    // 2*q_m[8]
  logic signed [CNT_W-1:0] nq8_x2;   // 2*~q_m[8]
  logic signed [CNT_W-1:0] cnt_q;
  logic signed [CNT_W-1:0] cnt_d;
  tmds_sym_t               sym_q;
  tmds_sym_t               sym_d;

  always_comb begin
    n1q    = popcount8(q_m_q[7:0]);
    n0q    = 4'd8 - n1q;
    diff   = $signed({{(CNT_W-4){1'b0}}, n1q}) - $signed({{(CNT_W-4){1'b0}}, n0q});
    q8_x2  = {{(CNT_W-2){1'b0}}, q_m_q[8], 1'b0};
    nq8_x2 = {{(CNT_W-2){1'b0}}, ~q_m_q[8], 1'b0};
    sym_d  = CTRL_00;
    cnt_d  = cnt_q;
    if (!de_q) begin
      // Blanking always re-centres disparity so each line starts balanced.
      cnt_d = CNT_ZERO;
      case (ctrl_q)
        2'b00:   sym_d = CTRL_00;
        2'b01:   sym_d = CTRL_01;
        2'b10:   sym_d = CTRL_10;
        default: sym_d = CTRL_11;
      endcase
    end else if ((cnt_q == CNT_ZERO) || (n1q == n0q)) begin
      sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > CNT_ZERO) && (n1q > n0q)) ||
                 ((cnt_q < CNT_ZERO) && (n0q > n1q))) begin
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + q8_x2 - diff;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q + diff - nq8_x2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m_q  <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      cnt_q  <= CNT_ZERO;
      sym_q  <= CTRL_00;
    end else begin
      q_m_q  <= q_m_d;
      de_q   <= de;
      ctrl_q <= ctrl;
      cnt_q  <= cnt_d;
      sym_q  <= sym_d;
    end
  end

  assign sym = sym_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder. Maps blue/green/red onto channels 0/1/2;
// channel 0 carries {vsync,hsync} during blanking, channels 1 and 2 carry
// fixed control pairs. Every symbol lags its inputs by two clocks.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-low reset
//   de                  data enable
//   blue, green, red    pixel components
//   hsync, vsync        sync, used on channel 0 only while de==0
//   sym0, sym1, sym2    10-bit TMDS symbols to the serializers
module dvi_tmds_encoder
  import tmds_pkg::*;
#(
  parameter logic [1:0] CH1_CTRL = 2'b00,
  parameter logic [1:0] CH2_CTRL = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] blue,
  input  logic [7:0] green,
  input  logic [7:0] red,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] sym0,
  output logic [9:0] sym1,
  output logic [9:0] sym2
);

  tmds_channel_enc u_ch0 (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .d    (blue),
    .ctrl ({vsync, hsync}),
    .sym  (sym0)
  );

  tmds_channel_enc u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .d    (green),
    .ctrl (CH1_CTRL),
    .sym  (sym1)
  );

  tmds_channel_enc u_ch2 (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .d    (red),
    .ctrl (CH2_CTRL),
    .sym  (sym2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
module tb_dvi_tmds_encoder;

  logic       clk;
  logic       rst;
  logic       de;
  logic [7:0] blue, green, red;
  logic       hsync, vsync;
  logic [9:0] sym0, sym1, sym2;

  dvi_tmds_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .de    (de),
    .blue  (blue),
    .green (green),
    .red   (red),
    .hsync (hsync),
    .vsync (vsync),
    .sym0  (sym0),
    .sym1  (sym1),
    .sym2  (sym2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic       de;
    logic [9:0] s0, s1, s2;
    logic [7:0] d0, d1, d2;
    int         c0, c1, c2;
  } ent_t;

  ent_t exp_q[$];
  int   mcnt[3];
  int   dut_sum[3];

  typedef struct packed {
    logic       de;
    logic [7:0] pix;
    logic       hs;
    logic       vs;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Reference encoder: plain integer disparity, rules applied directly.
  task automatic model_enc(input int ch, input logic de_v, input logic [7:0] d,
                           input logic [1:0] c, output logic [9:0] s);
    int n1, n1q, n0q;
    logic use_xnor;
    logic [8:0] qm;
    if (!de_v) begin
      mcnt[ch] = 0;
      s = ctrl_code(c);
    end else begin
      n1 = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (mcnt[ch] == 0 || n1q == n0q) begin
        s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        mcnt[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((mcnt[ch] > 0 && n1q > n0q) || (mcnt[ch] < 0 && n0q > n1q)) begin
        s = {1'b1, qm[8], ~qm[7:0]};
        mcnt[ch] += 2 * int'(qm[8]) + (n0q - n1q);
      end else begin
        s = {1'b0, qm[8], qm[7:0]};
        mcnt[ch] += (n1q - n0q) - 2 * int'(!qm[8]);
      end
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] dut_sym(input int ch);
    if (ch == 0) return sym0;
    if (ch == 1) return sym1;
    return sym2;
  endfunction

  task automatic check_out(input ent_t e);
    logic [9:0] act, exp_s;
    logic [7:0] exp_d;
    int exp_c;
    for (int ch = 0; ch < 3; ch++) begin
      act   = dut_sym(ch);
      exp_s = (ch == 0) ? e.s0 : (ch == 1) ? e.s1 : e.s2;
      exp_d = (ch == 0) ? e.d0 : (ch == 1) ? e.d1 : e.d2;
      exp_c = (ch == 0) ? e.c0 : (ch == 1) ? e.c1 : e.c2;
      check($sformatf("model_sym%0d", ch), int'(act), int'(exp_s));
      if (e.de) begin
        check($sformatf("decode%0d", ch), int'(decode(act)), int'(exp_d));
        dut_sum[ch] += 2 * $countones(act) - 10;
        check($sformatf("cnt_sum%0d", ch), dut_sum[ch], exp_c);
        check($sformatf("cnt_bound%0d", ch), int'(dut_sum[ch] <= 16 && dut_sum[ch] >= -16), 1);
      end else begin
        dut_sum[ch] = 0;
      end
    end
  endtask

  task automatic drive(input logic de_v, input logic [7:0] b, input logic [7:0] g,
                       input logic [7:0] r, input logic hs, input logic vs);
    ent_t e;
    logic [9:0] s;
    de = de_v; blue = b; green = g; red = r; hsync = hs; vsync = vs;
    e.de = de_v; e.d0 = b; e.d1 = g; e.d2 = r;
    model_enc(0, de_v, b, {vs, hs}, s);     e.s0 = s; e.c0 = mcnt[0];
    model_enc(1, de_v, g, 2'b00, s);        e.s1 = s; e.c1 = mcnt[1];
    model_enc(2, de_v, r, 2'b00, s);        e.s2 = s; e.c2 = mcnt[2];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_out(e);
  endtask

  task automatic do_reset();
    ent_t e;
    @(posedge clk);
    #3;
    rst = 1'b0;
    de = 1'b0; blue = 8'h00; green = 8'h00; red = 8'h00; hsync = 1'b0; vsync = 1'b0;
    #1;
    check("rst_sym0", int'(sym0), 'h354);
    check("rst_sym1", int'(sym1), 'h354);
    check("rst_sym2", int'(sym2), 'h354);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    e.de = 1'b0;
    e.s0 = 10'h354; e.s1 = 10'h354; e.s2 = 10'h354;
    e.d0 = '0; e.d1 = '0; e.d2 = '0;
    e.c0 = 0; e.c1 = 0; e.c2 = 0;
    exp_q.push_back(e);
    for (int ch = 0; ch < 3; ch++) begin
      mcnt[ch] = 0;
      dut_sum[ch] = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb, rg, rr;
    rst = 1'b0;
    de = 1'b0; blue = '0; green = '0; red = '0; hsync = 1'b0; vsync = 1'b0;

    //            de  pix    hs vs   sym0    sym1    sym2
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h0AB, 10'h354, 10'h354};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'h154, 10'h354, 10'h354};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 10'h2AB, 10'h354, 10'h354};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h354, 10'h354, 10'h354};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h354, 10'h354, 10'h354};
    tbl[7]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 10'h200, 10'h200, 10'h200};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h0AB, 10'h354, 10'h354};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
    tbl[10] = '{1'b1, 8'hFF, 1'b0, 1'b0, 10'h0FF, 10'h0FF, 10'h0FF};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h354, 10'h354, 10'h354};

    do_reset();

    // Table vectors; each row's symbols appear after the following edge.
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(tbl[i].de, tbl[i].pix, tbl[i].pix, tbl[i].pix, tbl[i].hs, tbl[i].vs);
      else        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      if (i >= 1) begin
        check($sformatf("tbl%0d_sym0", i-1), int'(sym0), int'(tbl[i-1].e0));
        check($sformatf("tbl%0d_sym1", i-1), int'(sym1), int'(tbl[i-1].e1));
        check($sformatf("tbl%0d_sym2", i-1), int'(sym2), int'(tbl[i-1].e2));
      end
    end

    // Latency: isolated marker pixel shows up on all channels together.
    repeat (3) drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("lat_early_sym0", int'(sym0), 'h354);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("lat_sym0", int'(sym0), 'h100);
    check("lat_sym1", int'(sym1), 'h100);
    check("lat_sym2", int'(sym2), 'h100);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("lat_after_sym0", int'(sym0), 'h354);

    // Reset in the middle of an active line.
    drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    check("post_rst_sym0", int'(sym0), 'h100);
    check("post_rst_sym2", int'(sym2), 'h100);

    // Random pixels, random de, sync noise.
    for (int n = 0; n < 10000; n++) begin
      rb = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF) : 8'($urandom);
      rg = 8'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 8'h0F : 8'($urandom);
      drive($urandom_range(0, 4) != 0, rb, rg, rr, 1'($urandom), 1'($urandom));
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
